// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush/stall control and MADD/MSUB feedback of hilo/cnt.
// Define EX_MEM_EXCEPT_EN to build the CP0 and exception registers; otherwise they read zero and flush is ignored.
module ex_mem_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        mem_stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        ex_cp0_reg_we,
    input  logic [4:0]  ex_cp0_reg_write_addr,
    input  logic [31:0] ex_cp0_reg_data,
    input  logic [31:0] ex_excepttype,
    input  logic [31:0] ex_current_inst_addr,
    input  logic        ex_is_in_delayslot,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2,
    output logic        mem_cp0_reg_we,
    output logic [4:0]  mem_cp0_reg_write_addr,
    output logic [31:0] mem_cp0_reg_data,
    output logic [31:0] mem_excepttype,
    output logic [31:0] mem_current_inst_addr,
    output logic        mem_is_in_delayslot,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o,
    output logic        mem_valid
);

    logic flush_eff;
    logic bubble;

`ifdef EX_MEM_EXCEPT_EN
    assign flush_eff = flush;
`else
    assign flush_eff = 1'b0;
`endif

    assign bubble = ex_stall && !mem_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_valid    <= 1'b0;
        end else if (flush_eff || bubble) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_valid    <= 1'b0;
        end else if (!mem_stall) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            mem_valid    <= 1'b1;
        end
    end

    // The partial product only survives while EX is held alone; cnt_i==3 passes through untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else if (flush_eff) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else if (bubble) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else if (!mem_stall) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end
    end

`ifdef EX_MEM_EXCEPT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_cp0_reg_we         <= 1'b0;
            mem_cp0_reg_write_addr <= '0;
            mem_cp0_reg_data       <= '0;
            mem_excepttype         <= '0;
            mem_current_inst_addr  <= '0;
            mem_is_in_delayslot    <= 1'b0;
        end else if (flush_eff || bubble) begin
            mem_cp0_reg_we         <= 1'b0;
            mem_cp0_reg_write_addr <= '0;
            mem_cp0_reg_data       <= '0;
            mem_excepttype         <= '0;
            mem_current_inst_addr  <= '0;
            mem_is_in_delayslot    <= 1'b0;
        end else if (!mem_stall) begin
            mem_cp0_reg_we         <= ex_cp0_reg_we;
            mem_cp0_reg_write_addr <= ex_cp0_reg_write_addr;
            mem_cp0_reg_data       <= ex_cp0_reg_data;
            mem_excepttype         <= ex_excepttype;
            mem_current_inst_addr  <= ex_current_inst_addr;
            mem_is_in_delayslot    <= ex_is_in_delayslot;
        end
    end
`else
    logic unused_exc_inputs;
    assign unused_exc_inputs = ^{flush, ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data,
                                 ex_excepttype, ex_current_inst_addr, ex_is_in_delayslot};

    assign mem_cp0_reg_we         = 1'b0;
    assign mem_cp0_reg_write_addr = '0;
    assign mem_cp0_reg_data       = '0;
    assign mem_excepttype         = '0;
    assign mem_current_inst_addr  = '0;
    assign mem_is_in_delayslot    = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios followed by randomized cycles against a bundle-level model.
module tb_ex_mem_reg;

`ifdef EX_MEM_EXCEPT_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, ex_stall, mem_stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi, ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic        ex_cp0_reg_we;
    logic [4:0]  ex_cp0_reg_write_addr;
    logic [31:0] ex_cp0_reg_data, ex_excepttype, ex_current_inst_addr;
    logic        ex_is_in_delayslot;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_write_addr;
    logic [31:0] mem_cp0_reg_data, mem_excepttype, mem_current_inst_addr;
    logic        mem_is_in_delayslot;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic        mem_valid;

    // Inputs and outputs viewed as whole bundles so the model works on slots, not fields.
    logic [174:0] pay_in, pay_obs;
    logic [102:0] exc_in, exc_obs;
    assign pay_in  = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2};
    assign pay_obs = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2};
    assign exc_in  = {ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data, ex_excepttype,
                      ex_current_inst_addr, ex_is_in_delayslot};
    assign exc_obs = {mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_excepttype,
                      mem_current_inst_addr, mem_is_in_delayslot};

    logic [174:0] exp_pay;
    logic [102:0] exp_exc;
    logic         exp_valid;
    logic [63:0]  exp_hilo;
    logic [1:0]   exp_cnt;

    int compared = 0;
    int mismatched = 0;

    ex_mem_reg dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
        .ex_cp0_reg_data(ex_cp0_reg_data), .ex_excepttype(ex_excepttype),
        .ex_current_inst_addr(ex_current_inst_addr), .ex_is_in_delayslot(ex_is_in_delayslot),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data), .mem_excepttype(mem_excepttype),
        .mem_current_inst_addr(mem_current_inst_addr), .mem_is_in_delayslot(mem_is_in_delayslot),
        .hilo_o(hilo_o), .cnt_o(cnt_o), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "/payload"}, 256'(pay_obs), 256'(exp_pay));
        checkVal({tag, "/except"}, 256'(exc_obs), 256'(exp_exc));
        checkVal({tag, "/valid"}, 256'(mem_valid), 256'(exp_valid));
        checkVal({tag, "/hilo"}, 256'(hilo_o), 256'(exp_hilo));
        checkVal({tag, "/cnt"}, 256'(cnt_o), 256'(exp_cnt));
    endtask

    task automatic modelReset();
        exp_pay = '0; exp_exc = '0; exp_valid = 1'b0; exp_hilo = '0; exp_cnt = '0;
    endtask

    // What the MEM slot should hold after one edge, decided from the control inputs at that edge.
    task automatic modelEdge();
        if (EXC_EN && flush) begin
            modelReset();
        end else if (ex_stall && !mem_stall) begin
            exp_pay = '0; exp_exc = '0; exp_valid = 1'b0;
            exp_hilo = hilo_i; exp_cnt = cnt_i;
        end else if (!mem_stall) begin
            exp_pay = pay_in; exp_exc = EXC_EN ? exc_in : '0; exp_valid = 1'b1;
            exp_hilo = '0; exp_cnt = '0;
        end
    endtask

    task automatic randomizeData();
        {ex_wd, ex_wreg, ex_wdata, ex_whilo} = {$urandom(), $urandom()};
        {ex_hi, ex_lo, ex_aluop} = {$urandom(), $urandom(), $urandom()};
        {ex_mem_addr, ex_reg2} = {$urandom(), $urandom()};
        {ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data} = {$urandom(), $urandom()};
        {ex_excepttype, ex_current_inst_addr, ex_is_in_delayslot} = {$urandom(), $urandom(), $urandom()};
        hilo_i = {$urandom(), $urandom()};
        cnt_i  = 2'($urandom_range(0, 3));
    endtask

    task automatic applyStimulus(input logic f, input logic es, input logic ms);
        flush = f; ex_stall = es; mem_stall = ms;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Drops resetn between edges, checks the outputs clear before the next edge, then releases it.
    task automatic pulseReset(input string tag);
        #2 resetn = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"});
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0; ex_stall = 1'b0; mem_stall = 1'b0;
        randomizeData();
        modelReset();
        #12;
        checkOutput("reset");
        resetn = 1'b1;

        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pass");
        checkVal("pass_wd", 256'(mem_wd), 256'(5'd3));
        checkVal("pass_wdata", 256'(mem_wdata), 256'(32'h1234_5678));
        checkVal("pass_valid", 256'(mem_valid), 256'(1'b1));

        randomizeData();
        hilo_i = 64'hA; cnt_i = 2'd1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("bubble");
        checkVal("bubble_wreg", 256'(mem_wreg), 256'(1'b0));
        checkVal("bubble_valid", 256'(mem_valid), 256'(1'b0));
        checkVal("bubble_hilo", 256'(hilo_o), 256'(64'hA));
        checkVal("bubble_cnt", 256'(cnt_o), 256'(2'd1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("unstall_cnt", 256'(cnt_o), 256'(2'd0));

        hilo_i = 64'h5; cnt_i = 2'd3;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkVal("cnt3_cnt", 256'(cnt_o), 256'(2'd3));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("both_stall_hold");

        ex_wdata = 32'hCAFE;
        applyStimulus(1'b0, 1'b0, 1'b0);
        ex_wdata = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkVal("hold_wdata", 256'(mem_wdata), 256'(32'hCAFE));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("release_wdata", 256'(mem_wdata), 256'(32'hBEEF));

        ex_excepttype = 32'h200;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("flush_over_stall");
        checkVal("flush_excepttype", 256'(mem_excepttype), 256'(32'h0));

        ex_wdata = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("pre_reset_wdata", 256'(mem_wdata), 256'(32'hFFFF_FFFF));
        pulseReset("async_reset");

        hilo_i = 64'h1234; cnt_i = 2'd2;
        applyStimulus(1'b0, 1'b1, 1'b0);
        pulseReset("reset_mid_madd");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after_reset_normal");

        ex_cp0_reg_we = 1'b1; ex_excepttype = 32'h400;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cp0_capture");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("flush_alone");

        for (int n = 0; n < 200; n++) begin
            randomizeData();
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            checkOutput("random");
            if (n % 64 == 63) pulseReset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
